// File: rtl/avr_ctrl_pkg.sv
// Shared control-unit definitions: decoded instruction IDs and the common
// sequencer state encoding used across the control_unit blocks.
package avr_ctrl_pkg;

  // Decoded instruction IDs produced by the decode stage
  localparam logic [7:0] ID_NOP      = 8'h00;
  localparam logic [7:0] ID_LPM_R0   = 8'h22;
  localparam logic [7:0] ID_LPM_RD   = 8'h23;
  localparam logic [7:0] ID_LPM_RDZP = 8'h24;

  // Common multi-cycle sequencer state encoding
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_READ = S_READ,
    ST_WB   = S_WB
  } lpm_state_e;

  // Which LPM form was accepted; only the Z+ form post-increments Z
  typedef enum logic [1:0] {
    VAR_R0   = 2'd0,
    VAR_RD   = 2'd1,
    VAR_RDZP = 2'd2
  } lpm_var_e;

endpackage

// File: rtl/lpm_sequencer.sv
// Multi-cycle sequencer for the LPM instruction family. Stalls fetch while the
// program memory is read through the Z pointer, then issues the register-file
// writeback and the optional Z post-increment.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for an LPM from decode; stall only in the accept cycle
// READ  | PM address mux on Z for PM_LAT cycles (down-counter to 0)
// WB    | register write (and Z+ for LPM Rd,Z+); fetch resumes
module lpm_sequencer
  import avr_ctrl_pkg::*;
#(
  parameter int ID_W   = 8,
  parameter int PM_LAT = 1
) (
  input  logic            clk_i,
  input  logic            reset_n_i,
  input  logic            instr_valid_i,
  input  logic [ID_W-1:0] instruction_id_i,
  input  logic            z_lsb_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            lpm_enable_o,
  output logic            pm_byte_sel_o,
  output logic            rd_sel_r0_o,
  output logic            rd_we_o,
  output logic            z_inc_o,
  output logic            done_o
);

  if (PM_LAT < 1 || PM_LAT > 7) begin : g_pm_lat_range
    $error("lpm_sequencer: PM_LAT=%0d outside legal range 1..7", PM_LAT);
  end

  lpm_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  lpm_var_e   var_q, var_d;
  logic       zlsb_q, zlsb_d;
  logic       r0_q, r0_d;

  logic       id_is_lpm;
  lpm_var_e   id_var;
  logic       accept;

  // Classify the incoming decoded ID
  always_comb begin
    id_is_lpm = 1'b1;
    id_var    = VAR_R0;
    if (instruction_id_i == ID_W'(ID_LPM_R0)) begin
      id_var = VAR_R0;
    end else if (instruction_id_i == ID_W'(ID_LPM_RD)) begin
      id_var = VAR_RD;
    end else if (instruction_id_i == ID_W'(ID_LPM_RDZP)) begin
      id_var = VAR_RDZP;
    end else begin
      id_is_lpm = 1'b0;
    end
  end

  // Accept is gated by reset so stall stays low while reset is held
  assign accept = reset_n_i && (state_q == ST_IDLE) && instr_valid_i &&
                  !flush_i && id_is_lpm;

  // Next-state, latency counter and latched instruction fields
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    var_d   = var_q;
    zlsb_d  = zlsb_q;
    r0_d    = r0_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_READ;
          cnt_d   = 3'(PM_LAT - 1);
          var_d   = id_var;
          zlsb_d  = z_lsb_i;
          r0_d    = (id_var == VAR_R0);
        end
      end
      ST_READ: begin
        if (cnt_q == 3'd0) begin
          state_d = ST_WB;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_WB: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // A redirect abandons the instruction whatever phase it is in
    if (flush_i) begin
      state_d = ST_IDLE;
    end
  end

  // State and latched-field registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      var_q   <= VAR_R0;
      zlsb_q  <= 1'b0;
      r0_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      var_q   <= var_d;
      zlsb_q  <= zlsb_d;
      r0_q    <= r0_d;
    end
  end

  // Moore outputs from registered state; stall adds the combinational accept.
  // Everything is forced low while reset is held, even before the reset edge.
  always_comb begin
    stall_o       = reset_n_i && (accept || (state_q == ST_READ));
    busy_o        = reset_n_i && (state_q != ST_IDLE);
    lpm_enable_o  = reset_n_i && (state_q == ST_READ);
    pm_byte_sel_o = reset_n_i && zlsb_q;
    rd_sel_r0_o   = reset_n_i && r0_q;
    done_o        = reset_n_i && (state_q == ST_WB);
    rd_we_o       = reset_n_i && (state_q == ST_WB) && !flush_i;
    z_inc_o       = reset_n_i && (state_q == ST_WB) && !flush_i &&
                    (var_q == VAR_RDZP);
  end

endmodule
